// File: rtl/serial_word_collector.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_collector
//  Description : Collects a frame of N serial bits (MSB first), optionally
//                followed by an even-parity bit, and presents the completed
//                word together with a one-cycle load strobe.
//                load drives the enable of a downstream register and word_out
//                drives its data input, so each word is captured exactly once.
//  Ports       : clock      - rising-edge clock
//                reset      - synchronous active-high reset
//                start      - begin a frame (only honoured in IDLE)
//                ser_in     - serial data bit, qualified by ser_valid
//                ser_valid  - ser_in carries a bit this cycle
//                word_out   - last completed word, stable between frames
//                load       - one-cycle strobe, word_out is new
//                busy       - high while a frame is in progress (SHIFT/PARITY/DONE)
//                parity_err - parity result of last frame (0 when PARITY_EN=0)
//  Revision    : 1.0  initial release
// ============================================================================
module serial_word_collector #(
  parameter int N         = 8,
  parameter int PARITY_EN = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         ser_in,
  input  logic         ser_valid,
  output logic [N-1:0] word_out,
  output logic         load,
  output logic         busy,
  output logic         parity_err
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [N-1:0]       r_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic [N-1:0]       r_word;
  logic               r_load;
  logic               r_busy;
  logic               r_perr;
  logic               w_last_bit;

  // The N-th valid data bit of the frame is being accepted this cycle.
  assign w_last_bit = (r_state == S_SHIFT) && ser_valid && (r_cnt == c_LAST_CNT);

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_last_bit) w_next = (PARITY_EN != 0) ? S_PARITY : S_DONE;
      end
      S_PARITY: begin
        if (ser_valid) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_word <= '0;
      r_load <= 1'b0;
      r_busy <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      // load is a single-cycle pulse: it is only set on the edge entering DONE.
      r_load <= 1'b0;
      // busy follows the state being entered, so it is high exactly in
      // SHIFT/PARITY/DONE without an extra cycle of lag.
      r_busy <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_perr <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (ser_valid) begin
            r_sr <= {r_sr[N-2:0], ser_in};
            // Count saturates at N-1 so it never wraps within a frame.
            if (r_cnt != c_LAST_CNT) r_cnt <= r_cnt + CNT_W'(1);
            if (w_last_bit && (PARITY_EN == 0)) begin
              r_word <= {r_sr[N-2:0], ser_in};
              r_load <= 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (ser_valid) begin
            r_word <= r_sr;
            // Even parity: total ones including the parity bit must be even.
            r_perr <= (^r_sr) ^ ser_in;
            r_load <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign word_out   = r_word;
  assign load       = r_load;
  assign busy       = r_busy;
  assign parity_err = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_word_collector
//  Description : Self-checking bench for serial_word_collector. Two instances
//                (no parity / even parity, N=8) are driven one at a time.
//                Table-driven frames, hand-written reset/ignore sequences and
//                randomized frames checked against frame-level expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_word_collector;

  logic       clk;
  logic       rst;
  logic       start0, ser_in0, ser_valid0;
  logic       start1, ser_in1, ser_valid1;
  logic [7:0] word0, word1;
  logic       load0, load1, busy0, busy1, perr0, perr1;

  int checks   = 0;
  int failures = 0;
  int cur_sel  = 0;

  logic [7:0] prev_word [2];
  logic       prev_perr [2];

  logic [7:0] word_s;
  logic       load_s, busy_s, perr_s;

  serial_word_collector #(.N(8), .PARITY_EN(0)) u_dut0 (
    .clock(clk), .reset(rst), .start(start0), .ser_in(ser_in0),
    .ser_valid(ser_valid0), .word_out(word0), .load(load0),
    .busy(busy0), .parity_err(perr0)
  );

  serial_word_collector #(.N(8), .PARITY_EN(1)) u_dut1 (
    .clock(clk), .reset(rst), .start(start1), .ser_in(ser_in1),
    .ser_valid(ser_valid1), .word_out(word1), .load(load1),
    .busy(busy1), .parity_err(perr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    word_s = (cur_sel == 1) ? word1 : word0;
    load_s = (cur_sel == 1) ? load1 : load0;
    busy_s = (cur_sel == 1) ? busy1 : busy0;
    perr_s = (cur_sel == 1) ? perr1 : perr0;
  end

  typedef struct {
    int         sel;
    logic [7:0] w;
    logic       p;
    int         gap;
    bit         glitch;
    logic [7:0] exp_w;
    logic       exp_pe;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic st, input logic v, input logic d);
    if (sel == 1) begin
      start1 = st; ser_valid1 = v; ser_in1 = d;
      start0 = 1'b0; ser_valid0 = 1'b0; ser_in0 = 1'b0;
    end else begin
      start0 = st; ser_valid0 = v; ser_in0 = d;
      start1 = 1'b0; ser_valid1 = 1'b0; ser_in1 = 1'b0;
    end
  endtask

  task automatic obs(input int idx, inout int nload, inout int load_idx,
                     inout logic [7:0] wo, inout logic pe);
    if (load_s) begin
      nload++;
      if (load_idx < 0) begin
        load_idx = idx;
        wo       = word_s;
        pe       = perr_s;
      end
    end
  endtask

  // One complete frame. gap >= 0: exactly gap idle cycles before each bit;
  // gap < 0: a random 0..-gap idle cycles before each bit. glitch pulses
  // start during SHIFT gaps and during the DONE cycle.
  task automatic run_frame(input int sel, input logic [7:0] w, input logic p,
                           input int gap, input bit glitch,
                           input logic [7:0] exp_w, input logic exp_pe);
    int         nbits;
    logic [8:0] bits;
    int         idx, last_idx, load_idx, nload, nbusy, g;
    logic [7:0] wo;
    logic       pe, d;
    nbits = (sel == 1) ? 9 : 8;
    bits = {w, p};
    idx = 0; last_idx = -1; load_idx = -1; nload = 0; nbusy = 0;
    wo = '0; pe = 1'b0;
    cur_sel = sel;
    #0;
    // word_out and parity_err hold from the previous frame until start
    chk("hold_word", {24'd0, word_s}, {24'd0, prev_word[sel]});
    chk("hold_perr", {31'd0, perr_s}, {31'd0, prev_perr[sel]});
    drive(sel, 1'b1, 1'b0, 1'b0);
    step(); idx++;
    chk("busy_after_start", {31'd0, busy_s}, 32'd1);
    chk("perr_cleared", {31'd0, perr_s}, 32'd0);
    for (int b = 0; b < nbits; b++) begin
      g = (gap >= 0) ? gap : int'($urandom_range(0, -gap));
      for (int j = 0; j < g; j++) begin
        drive(sel, glitch, 1'b0, 1'($urandom));
        step(); idx++;
        obs(idx, nload, load_idx, wo, pe);
      end
      d = (sel == 1) ? bits[8-b] : w[7-b];
      drive(sel, 1'b0, 1'b1, d);
      step(); idx++;
      last_idx = idx;
      obs(idx, nload, load_idx, wo, pe);
    end
    // DONE cycle: a start here must be ignored
    drive(sel, glitch, 1'b0, 1'b0);
    step(); idx++;
    obs(idx, nload, load_idx, wo, pe);
    drive(sel, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      if (busy_s) nbusy++;
      step(); idx++;
      obs(idx, nload, load_idx, wo, pe);
    end
    if (busy_s) nbusy++;
    chk("load_count", nload, 1);
    chk("load_latency", load_idx, last_idx);
    chk("word_at_load", {24'd0, wo}, {24'd0, exp_w});
    chk("perr_at_load", {31'd0, pe}, {31'd0, exp_pe});
    chk("busy_after_frame", nbusy, 0);
    chk("word_stable", {24'd0, word_s}, {24'd0, exp_w});
    prev_word[sel] = exp_w;
    prev_perr[sel] = exp_pe;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int activity;
    int sel;
    logic [7:0] w;
    logic p;

    tbl[0] = '{0, 8'hA5, 1'b0, 0, 1'b0, 8'hA5, 1'b0};
    tbl[1] = '{0, 8'hA5, 1'b0, 1, 1'b0, 8'hA5, 1'b0};
    tbl[2] = '{0, 8'h01, 1'b1, 0, 1'b1, 8'h01, 1'b0};
    tbl[3] = '{1, 8'hA5, 1'b0, 0, 1'b0, 8'hA5, 1'b0};
    tbl[4] = '{1, 8'hA5, 1'b1, 0, 1'b0, 8'hA5, 1'b1};
    tbl[5] = '{1, 8'h3C, 1'b0, 1, 1'b1, 8'h3C, 1'b0};
    tbl[6] = '{1, 8'h00, 1'b1, 2, 1'b0, 8'h00, 1'b1};
    tbl[7] = '{1, 8'h01, 1'b0, 0, 1'b1, 8'h01, 1'b1};

    // Reset, with start/valid asserted to show reset overrides them
    rst = 1'b1;
    start0 = 1'b1; ser_valid0 = 1'b1; ser_in0 = 1'b1;
    start1 = 1'b1; ser_valid1 = 1'b1; ser_in1 = 1'b1;
    step(); step();
    chk("rst_word0", {24'd0, word0}, 32'd0);
    chk("rst_load0", {31'd0, load0}, 32'd0);
    chk("rst_busy0", {31'd0, busy0}, 32'd0);
    chk("rst_perr0", {31'd0, perr0}, 32'd0);
    chk("rst_word1", {24'd0, word1}, 32'd0);
    chk("rst_load1", {31'd0, load1}, 32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_perr1", {31'd0, perr1}, 32'd0);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    step();
    chk("post_rst_busy0", {31'd0, busy0}, 32'd0);
    prev_word[0] = '0; prev_word[1] = '0;
    prev_perr[0] = 1'b0; prev_perr[1] = 1'b0;

    // Table-driven frames
    for (int i = 0; i < 8; i++)
      run_frame(tbl[i].sel, tbl[i].w, tbl[i].p, tbl[i].gap, tbl[i].glitch,
                tbl[i].exp_w, tbl[i].exp_pe);

    // ser_valid toggling in IDLE produces no activity on either instance
    activity = 0;
    for (int j = 0; j < 8; j++) begin
      ser_valid0 = j[0]; ser_in0 = j[1];
      ser_valid1 = j[0]; ser_in1 = j[1];
      step();
      if (load0 || busy0 || load1 || busy1) activity++;
    end
    chk("idle_valid_ignored", activity, 0);
    chk("idle_word_hold", {24'd0, word1}, {24'd0, prev_word[1]});

    // Reset after 4 bits of 8'h3C, then a full 8'hF0 frame
    cur_sel = 0;
    drive(0, 1'b1, 1'b0, 1'b0);
    step();
    activity = 0;
    for (int b = 0; b < 4; b++) begin
      w = 8'h3C;
      drive(0, 1'b0, 1'b1, w[7-b]);
      step();
      if (load0) activity++;
    end
    rst = 1'b1;
    drive(0, 1'b0, 1'b1, 1'b1);
    step();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    if (load0) activity++;
    chk("abort_word", {24'd0, word0}, 32'd0);
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    for (int j = 0; j < 10; j++) begin
      step();
      if (load0 || busy0) activity++;
    end
    chk("abort_no_load", activity, 0);
    prev_word[0] = '0; prev_word[1] = '0;
    prev_perr[0] = 1'b0; prev_perr[1] = 1'b0;
    run_frame(0, 8'hF0, 1'b0, 0, 1'b0, 8'hF0, 1'b0);

    // Randomized frames against frame-level expectations
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 1));
      w   = 8'($urandom);
      p   = 1'($urandom);
      cur_sel = sel;
      activity = 0;
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        drive(sel, 1'b0, 1'($urandom), 1'($urandom));
        step();
        if (load_s || busy_s) activity++;
      end
      chk("rand_idle_quiet", activity, 0);
      run_frame(sel, w, p, -2, 1'($urandom), w,
                (sel == 1) ? ((^w) ^ p) : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
